// File: rtl/bcd_countdown_timer_pkg.sv
// rtl/bcd_countdown_timer_pkg.sv - shared constants, state encoding and digit clamp for the BCD countdown timer
// Purpose: single home for the digit width, BCD ceiling and FSM state encoding.
// Ports: none (package).
package bcd_countdown_timer_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Digits 10..15 are not BCD; they saturate to 9 so OUT never holds a non-BCD digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit_dec.sv
// rtl/bcd_countdown_timer_digit_dec.sv - combinational single-digit BCD decrement with borrow
// Purpose: one stage of the ripple-borrow decrement chain.
// Ports: digit (current BCD digit), borrow_in (decrement request from lower digit),
//        next_digit (decremented digit), borrow_out (request passed to the next digit).
module bcd_digit_dec
  import bcd_countdown_timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] next_digit,
  output logic               borrow_out
);

  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == '0) begin
        next_digit = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - cascadable BCD countdown timer with optional auto-reload
// Purpose: load a multi-digit BCD preset, decrement on qualified ticks, flag expiry.
// Ports: CLK, reset (sync active-high), load/load_val (preset capture, digit 0 in [3:0]),
//        start, pause, tick (control), OUT (registered count), busy (RUN or PAUSED),
//        zero (combinational OUT==0), done (one-cycle expiry pulse).
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      tick,
  output logic [DIGIT_W*DIGITS-1:0] OUT,
  output logic                      busy,
  output logic                      zero,
  output logic                      done
);

  localparam int W = DIGIT_W * DIGITS;

  logic [W-1:0]    cnt_q;
  logic [W-1:0]    reload_q;
  state_e          state_q;
  logic            done_q;
  logic            busy_q;

  logic [W-1:0]    load_sat;
  logic [W-1:0]    cnt_dec;
  logic [DIGITS:0] borrow;

  always_comb begin
    load_sat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_sat[i*DIGIT_W +: DIGIT_W] = bcd_clamp(load_val[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Digit 0 always receives the decrement; borrows ripple upward in one cycle.
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_digit_dec u_dec (
      .digit      (cnt_q[g*DIGIT_W +: DIGIT_W]),
      .borrow_in  (borrow[g]),
      .next_digit (cnt_dec[g*DIGIT_W +: DIGIT_W]),
      .borrow_out (borrow[g+1])
    );
  end

  assign zero = (cnt_q == '0);

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q    <= '0;
      reload_q <= '0;
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        cnt_q    <= load_sat;
        reload_q <= load_sat;
        state_q  <= ST_IDLE;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (zero) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (pause) begin
              state_q <= ST_PAUSED;
            end else if (zero) begin
              // Only reached in the cycle after an auto-reload expiry.
              if (AUTO_RELOAD != 0 && reload_q != '0) begin
                cnt_q <= reload_q;
              end else begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
              end
            end else if (tick) begin
              cnt_q <= cnt_dec;
              if (cnt_dec == '0) begin
                done_q <= 1'b1;
                if (!(AUTO_RELOAD != 0 && reload_q != '0)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          ST_PAUSED: begin
            if (start) begin
              state_q <= ST_RUN;
            end
          end
          default: begin
            // ST_DONE: held until load or reset.
          end
        endcase
      end
    end
  end

  assign OUT  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed self-checking bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

  logic       CLK;
  logic       reset, load, start, pause, tick;
  logic [7:0] load_val;
  logic [7:0] OUT;
  logic       busy, zero, done;

  logic       ar_reset, ar_load, ar_start, ar_pause, ar_tick;
  logic [7:0] ar_load_val;
  logic [7:0] ar_OUT;
  logic       ar_busy, ar_zero, ar_done;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt;
  int exp_v;

  bcd_countdown_timer #(.DIGITS(2), .AUTO_RELOAD(0)) dut (
    .CLK(CLK), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .tick(tick),
    .OUT(OUT), .busy(busy), .zero(zero), .done(done)
  );

  bcd_countdown_timer #(.DIGITS(2), .AUTO_RELOAD(1)) dut_ar (
    .CLK(CLK), .reset(ar_reset), .load(ar_load), .load_val(ar_load_val),
    .start(ar_start), .pause(ar_pause), .tick(ar_tick),
    .OUT(ar_OUT), .busy(ar_busy), .zero(ar_zero), .done(ar_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] ar_exp_out [8] = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
  logic       ar_exp_done[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0; load_val = 8'h00;
    ar_reset = 1'b1; ar_load = 1'b0; ar_start = 1'b0; ar_pause = 1'b0; ar_tick = 1'b0;
    ar_load_val = 8'h00;

    // Reset state
    cyc();
    chk("rst_out", OUT, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_zero", zero, 1'b1);
    reset = 1'b0;

    // Full countdown from 25
    load = 1'b1; load_val = 8'h25;
    cyc();
    load = 1'b0;
    chk("load25_out", OUT, 8'h25);
    chk("load25_busy", busy, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_out", OUT, 8'h25);
    tick = 1'b1;
    done_cnt = 0;
    for (int n = 24; n >= 0; n--) begin
      cyc();
      exp_v = ((n / 10) << 4) | (n % 10);
      chk($sformatf("cd_out_%0d", n), OUT, exp_v);
      chk($sformatf("cd_done_%0d", n), done, (n == 0));
      if (done) done_cnt++;
    end
    cyc();
    tick = 1'b0;
    if (done) done_cnt++;
    chk("cd_done_once", done_cnt, 1);
    chk("cd_after_out", OUT, 8'h00);
    chk("cd_after_busy", busy, 1'b0);

    // DONE ignores start
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("done_start_out", OUT, 8'h00);
    chk("done_start_busy", busy, 1'b0);
    chk("done_start_done", done, 1'b0);

    // Load clamping
    load = 1'b1; load_val = 8'hA3;
    cyc();
    chk("clamp_a3", OUT, 8'h93);
    load_val = 8'hFC;
    cyc();
    chk("clamp_fc", OUT, 8'h99);

    // Start from zero: immediate done
    load_val = 8'h00;
    cyc();
    load = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("zstart_done", done, 1'b1);
    chk("zstart_out", OUT, 8'h00);
    chk("zstart_busy", busy, 1'b0);
    cyc();
    chk("zstart_done_end", done, 1'b0);

    // Borrow across digits, pause, resume
    load = 1'b1; load_val = 8'h10;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0; tick = 1'b1;
    cyc();
    chk("borrow_09", OUT, 8'h09);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("pause_out", OUT, 8'h09);
    chk("pause_busy", busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("pause_hold_%0d", k), OUT, 8'h09);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("resume_out", OUT, 8'h09);
    cyc();
    chk("resume_08", OUT, 8'h08);

    // Mid-count load with tick high
    load = 1'b1; load_val = 8'h50;
    cyc();
    load = 1'b0; tick = 1'b0;
    chk("midload_out", OUT, 8'h50);
    chk("midload_busy", busy, 1'b0);

    // Reset mid-count with tick high
    load = 1'b1; load_val = 8'h43;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0; tick = 1'b1;
    cyc();
    chk("pre_reset_42", OUT, 8'h42);
    reset = 1'b1;
    cyc();
    reset = 1'b0; tick = 1'b0;
    chk("midreset_out", OUT, 8'h00);
    chk("midreset_busy", busy, 1'b0);

    // Single-step expiry from 01
    load = 1'b1; load_val = 8'h01;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0; tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("one_done", done, 1'b1);
    chk("one_out", OUT, 8'h00);
    chk("one_busy", busy, 1'b0);

    // Auto-reload instance
    cyc();
    ar_reset = 1'b0;
    ar_load = 1'b1; ar_load_val = 8'h03;
    cyc();
    ar_load = 1'b0; ar_start = 1'b1;
    cyc();
    ar_start = 1'b0;
    chk("ar_start_out", ar_OUT, 8'h03);
    ar_tick = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk($sformatf("ar_out_%0d", k), ar_OUT, ar_exp_out[k]);
      chk($sformatf("ar_done_%0d", k), ar_done, ar_exp_done[k]);
      chk($sformatf("ar_busy_%0d", k), ar_busy, 1'b1);
    end
    ar_tick = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Synchronous, cascadable BCD down-counter (countdown timer); the decrementing counterpart of the team's mod-10 up-counter.
- Loads a multi-digit BCD value, decrements on qualified ticks, and flags expiry.
- Feeds display/sequencing logic that needs "N events remaining" rather than "N events elapsed".

Parameters:
- DIGITS, 2, number of BCD digits (output width 4*DIGITS).
- AUTO_RELOAD, 0, when 1 the timer reloads the last loaded value on expiry and keeps running.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture load_val.
- load_val  input  4*DIGITS  BCD preset value, digit 0 in bits [3:0].
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- tick  input  1  count-enable strobe; one decrement per cycle with tick=1 in RUN.
- OUT  output  4*DIGITS  current BCD count, registered.
- busy  output  1  high in RUN and PAUSED.
- zero  output  1  combinational, OUT==0.
- done  output  1  one-cycle registered pulse on expiry.

Behaviour:
- Reset, synchronous and active-high: OUT=0, reload register=0, state=IDLE, done=0, busy=0.
- Control priority per cycle: reset > load > start > pause > tick.
- Load sanitising: each load_val digit >9 is clamped to 9 before storing to OUT and the reload register.
- States: IDLE, RUN, PAUSED, DONE; state encoding comes from the package.
- load, any state: OUT<=sanitised load_val, reload<=same, state<=IDLE, done<=0; a tick in the same cycle is ignored.
- IDLE + start:
  - OUT!=0: state<=RUN.
  - OUT==0: state<=DONE, done pulses next cycle.
- RUN + pause: state<=PAUSED, and a same-cycle tick is ignored.
- PAUSED + start: state<=RUN; tick is ignored while PAUSED.
- RUN + tick:
  - Decrement digit 0.
  - On digit value 0, the digit wraps to 9 and borrows into the next digit (ripple-borrow, single cycle, all digits).
- Expiry, in RUN when a tick takes OUT from 1 to 0: OUT=0 and done=1 in the same following cycle.
  - AUTO_RELOAD=0: state<=DONE.
  - AUTO_RELOAD=1: the next cycle loads OUT<=reload and stays RUN.
  - AUTO_RELOAD=1 with reload==0: state<=DONE.
- DONE: OUT holds 0, start is ignored, and only load or reset leaves the state.
- busy is registered and equals (state==RUN || state==PAUSED).
- Decrement latency: 1 cycle from tick to OUT update; OUT never shows a non-BCD digit.
- reset asserted mid-count overrides everything in that cycle.

Decomposition:
- Shared package holds:
  - BCD_MAX=4'd9.
  - State typedef/localparams ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE.
  - Digit width constant 4.
- Sub-module bcd_digit_dec, purely combinational, instantiated DIGITS times in a generate loop:
  - Inputs: digit, borrow_in.
  - Outputs: next_digit, borrow_out.
  - Rule: digit 0 with borrow_in gives 9 and borrow_out=1.
- Top module holds the FSM, registers, and reload storage.

Test Plan:
- Reset then load_val=8'h25, start, 25 ticks → OUT steps 25,24,…,20,19,…,01,00; done=1 exactly once, with OUT=00; state DONE and busy=0 afterwards.
- load_val=8'hA3 → OUT=8'h93 (clamp); load_val=8'h00 plus start → done pulse next cycle, no count.
- Load 8'h10, start, tick → OUT=8'h09 (borrow across digits); pause with tick high → OUT holds 09 for 5 cycles; start, tick → 08.
- AUTO_RELOAD=1, load 8'h03, start, continuous tick → OUT 03,02,01,00(done),03,02,…; done period 4 cycles.
- Mid-count load of 8'h50 during RUN → OUT=50, state IDLE, busy=0; reset with tick high at OUT=8'h42 → OUT=00 the next cycle.
- DONE state + start → no change; load 8'h01, start, tick → done pulse, OUT=00.
